// File: rtl/prach_pkg.sv
// Shared PRACH reshaper types: sample/channel widths and lock FSM states.
// Imported by prach_sync_lock and prach_deshape_ch.
package prach_pkg;

  typedef logic [15:0] sample_t;
  typedef logic [7:0]  chn_t;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    FILL     = 2'd1,
    LOCKED   = 2'd2
  } lock_state_t;

endpackage

// File: rtl/prach_delay.sv
// Fixed-depth shift-register delay line, optional synchronous clear.
// Tie i_rst low for pure data lines.
module prach_delay #(
  parameter int W = 16,
  parameter int D = 4
) (
  input  logic         clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_sr [D];

  always_ff @(posedge clk) begin
    if (i_rst) begin
      for (int i = 0; i < D; i++) r_sr[i] <= '0;
    end else begin
      r_sr[0] <= i_d;
      for (int i = 1; i < D; i++) r_sr[i] <= r_sr[i-1];
    end
  end

  assign o_q = r_sr[D-1];

endmodule

// File: rtl/prach_sync_lock.sv
// Sync lock FSM and expected-slot counter for PRACH reshapers.
// PRACH_DESHAPE_CHK_EN adds slot-sequence error outputs.
module prach_sync_lock
  import prach_pkg::*;
#(
  parameter int SIZE = 8,
  parameter int LAT  = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sync,
  output logic o_vld
`ifdef PRACH_DESHAPE_CHK_EN
  ,
  input  chn_t i_chn,
  output logic o_err,
  output logic o_err_sticky
`endif
);

  localparam int CW = $clog2(SIZE);
  localparam int WW = $clog2(LAT);

  lock_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [WW-1:0] r_wcnt;
  logic          r_vld;
  logic          w_mis;

  // a sync is misplaced when the slot counter did not expect slot 0
  assign w_mis = i_sync && (r_state != UNLOCKED) && (r_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= UNLOCKED;
      r_cnt   <= '0;
      r_wcnt  <= '0;
      r_vld   <= 1'b0;
    end else begin
      r_cnt <= i_sync ? CW'(1) : r_cnt + 1'b1;
      unique case (r_state)
        UNLOCKED: begin
          r_vld <= 1'b0;
          if (i_sync) begin
            r_state <= FILL;
            r_wcnt  <= WW'(LAT - 1);
          end
        end
        FILL: begin
          if (i_sync) begin
            r_wcnt <= WW'(LAT - 1);
          end else begin
            r_wcnt <= r_wcnt - 1'b1;
            if (r_wcnt == WW'(1)) begin
              r_state <= LOCKED;
              r_vld   <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (w_mis) begin
            r_state <= FILL;
            r_wcnt  <= WW'(LAT - 1);
            r_vld   <= 1'b0;
          end
        end
        default: begin
          r_state <= UNLOCKED;
          r_vld   <= 1'b0;
        end
      endcase
    end
  end

  assign o_vld = r_vld;

`ifdef PRACH_DESHAPE_CHK_EN
  logic w_err;
  logic r_err;
  logic r_sticky;

  assign w_err = ((r_state != UNLOCKED) && (i_chn != chn_t'(r_cnt)))
               || w_mis;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_err    <= w_err;
      r_sticky <= r_sticky | w_err;
    end
  end

  assign o_err        = r_err;
  assign o_err_sticky = r_sticky;
`endif

endmodule

// File: rtl/prach_deshape_ch.sv
// PRACH dp->dq channel deshaper with sync lock and output valid.
// Define PRACH_DESHAPE_CHK_EN to add chk_err / chk_err_sticky.
module prach_deshape_ch
  import prach_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  sample_t din_dp1,
  input  sample_t din_dp2,
  input  chn_t    din_chn,
  input  logic    sync_in,
  output sample_t dout_dq1,
  output sample_t dout_dq2,
  output chn_t    dout_chn,
  output logic    dout_vld,
  output logic    sync_out
`ifdef PRACH_DESHAPE_CHK_EN
  ,
  output logic    chk_err,
  output logic    chk_err_sticky
`endif
);

  localparam int HALF    = SIZE / 2;
  localparam int H       = $clog2(HALF);
  localparam int LATENCY = HALF + 1;

  logic    w_up;
  sample_t w_d2;
  sample_t w_dx_in;
  sample_t w_dx;
  logic [8:0] w_cs;
  sample_t r_dq1;
  sample_t r_dq2;

  assign w_up = din_chn[H];

  prach_delay #(.W(16), .D(HALF)) u_d2 (
    .clk   (clk),
    .i_rst (1'b0),
    .i_d   (din_dp2),
    .o_q   (w_d2)
  );

  // U half re-queues the delayed L.dp2 so it lands in the U output slot
  assign w_dx_in = w_up ? w_d2 : din_dp1;

  prach_delay #(.W(16), .D(HALF)) u_dx (
    .clk   (clk),
    .i_rst (1'b0),
    .i_d   (w_dx_in),
    .o_q   (w_dx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dq1 <= '0;
      r_dq2 <= '0;
    end else begin
      r_dq1 <= w_dx;
      r_dq2 <= w_up ? din_dp1 : w_d2;
    end
  end

  assign dout_dq1 = r_dq1;
  assign dout_dq2 = r_dq2;

  prach_delay #(.W(9), .D(LATENCY)) u_cs (
    .clk   (clk),
    .i_rst (rst),
    .i_d   ({sync_in, din_chn}),
    .o_q   (w_cs)
  );

  assign sync_out = w_cs[8];
  assign dout_chn = w_cs[7:0];

  prach_sync_lock #(.SIZE(SIZE), .LAT(LATENCY)) u_lock (
    .clk          (clk),
    .rst          (rst),
    .i_sync       (sync_in),
    .o_vld        (dout_vld)
`ifdef PRACH_DESHAPE_CHK_EN
    ,
    .i_chn        (din_chn),
    .o_err        (chk_err),
    .o_err_sticky (chk_err_sticky)
`endif
  );

endmodule

// File: tb/tb_prach_deshape_ch.sv
// Directed bench for prach_deshape_ch (SIZE=8, latency 5).
// Frames are built from a dq model; outputs checked against it.
module tb_prach_deshape_ch;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din_dp1, din_dp2, dout_dq1, dout_dq2;
  logic [7:0]  din_chn, dout_chn;
  logic        sync_in, dout_vld, sync_out;
`ifdef PRACH_DESHAPE_CHK_EN
  logic        chk_err, chk_err_sticky;
`endif

  always #5 clk = ~clk;

  prach_deshape_ch #(.SIZE(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .din_dp1  (din_dp1),
    .din_dp2  (din_dp2),
    .din_chn  (din_chn),
    .sync_in  (sync_in),
    .dout_dq1 (dout_dq1),
    .dout_dq2 (dout_dq2),
    .dout_chn (dout_chn),
    .dout_vld (dout_vld),
    .sync_out (sync_out)
`ifdef PRACH_DESHAPE_CHK_EN
    ,
    .chk_err        (chk_err),
    .chk_err_sticky (chk_err_sticky)
`endif
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n      = 0;

  logic [15:0] a [8];
  logic [15:0] b [8];
  logic [15:0] e1 [2048];
  logic [15:0] e2 [2048];
  logic [7:0]  ec [2048];
  bit          es [2048];
  bit          ek [2048];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // one input cycle; output of input n-4 is visible after this edge
  task automatic drive(input logic [7:0] c, input bit sy,
                       input logic [15:0] p1, input logic [15:0] p2,
                       input logic [15:0] x1, input logic [15:0] x2,
                       input bit ck, input bit xv);
    din_chn = c;
    sync_in = sy;
    din_dp1 = p1;
    din_dp2 = p2;
    e1[n] = x1;
    e2[n] = x2;
    ec[n] = c;
    es[n] = sy;
    ek[n] = ck;
    @(posedge clk);
    #1;
    if (n >= 4 && ek[n-4]) begin
      chk("dq1", 32'(dout_dq1), 32'(e1[n-4]));
      chk("dq2", 32'(dout_dq2), 32'(e2[n-4]));
      chk("chn", 32'(dout_chn), 32'(ec[n-4]));
      chk("sync", 32'(sync_out), 32'(es[n-4]));
    end
    chk("vld", 32'(dout_vld), 32'(xv));
    n++;
  endtask

  task automatic rst_cyc(input logic [7:0] c, input bit sy);
    drive(c, sy, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rst_dq1", 32'(dout_dq1), 32'h0);
    chk("rst_dq2", 32'(dout_dq2), 32'h0);
    chk("rst_chn", 32'(dout_chn), 32'h0);
    chk("rst_sync", 32'(sync_out), 32'h0);
`ifdef PRACH_DESHAPE_CHK_EN
    chk("rst_err", 32'(chk_err), 32'h0);
    chk("rst_sticky", 32'(chk_err_sticky), 32'h0);
`endif
  endtask

  // dq model: channel c carries (a[c], b[c]); dp is its transpose
  task automatic send_frame(input bit sy, input bit ck, input int vs,
                            input int c0, input int c1);
    logic [15:0] p1, p2;
    for (int c = c0; c < c1; c++) begin
      int k;
      k = c % 4;
      if (c < 4) begin
        p1 = a[k];
        p2 = a[k+4];
      end else begin
        p1 = b[k];
        p2 = b[k+4];
      end
      drive(8'(c), sy && (c == 0), p1, p2, a[c], b[c], ck, c >= vs);
    end
  endtask

  task automatic fill_ramp();
    for (int k = 0; k < 4; k++) begin
      a[k]   = 16'h10 + 16'(k);
      a[k+4] = 16'h20 + 16'(k);
      b[k]   = 16'h30 + 16'(k);
      b[k+4] = 16'h40 + 16'(k);
    end
  endtask

  task automatic fill_rnd();
    for (int k = 0; k < 8; k++) begin
      a[k] = 16'($urandom);
      b[k] = 16'($urandom);
    end
  endtask

  initial begin
    rst     = 1'b1;
    din_dp1 = '0;
    din_dp2 = '0;
    din_chn = '0;
    sync_in = 1'b0;
    for (int i = 0; i < 3; i++) rst_cyc(8'd0, 1'b0);
    rst = 1'b0;
    drive(8'd6, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);
    drive(8'd7, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0);

    fill_ramp();
    send_frame(1'b1, 1'b1, 4, 0, 8);
    for (int f = 0; f < 16; f++) begin
      fill_rnd();
      send_frame(1'b1, 1'b1, 0, 0, 8);
    end

    // truncated frame, then a sync where slot 3 was expected
    fill_rnd();
    send_frame(1'b1, 1'b0, 0, 0, 3);
`ifdef PRACH_DESHAPE_CHK_EN
    chk("err_pre", 32'(chk_err), 32'h0);
    chk("sticky_pre", 32'(chk_err_sticky), 32'h0);
`endif
    fill_rnd();
    send_frame(1'b1, 1'b1, 4, 0, 1);
`ifdef PRACH_DESHAPE_CHK_EN
    chk("err_mis", 32'(chk_err), 32'h1);
    chk("sticky_mis", 32'(chk_err_sticky), 32'h1);
`endif
    send_frame(1'b1, 1'b1, 4, 1, 8);
`ifdef PRACH_DESHAPE_CHK_EN
    chk("err_mis_end", 32'(chk_err), 32'h0);
`endif
    fill_rnd();
    send_frame(1'b1, 1'b1, 0, 0, 8);

    // skipped slot 7: frame 0..6 then a new frame
    fill_rnd();
    send_frame(1'b1, 1'b0, 0, 0, 7);
    fill_rnd();
    send_frame(1'b1, 1'b1, 4, 0, 1);
`ifdef PRACH_DESHAPE_CHK_EN
    chk("err_skip", 32'(chk_err), 32'h1);
`endif
    send_frame(1'b1, 1'b1, 4, 1, 2);
`ifdef PRACH_DESHAPE_CHK_EN
    chk("err_skip_end", 32'(chk_err), 32'h0);
    chk("sticky_skip", 32'(chk_err_sticky), 32'h1);
`endif
    send_frame(1'b1, 1'b1, 4, 2, 8);
    fill_rnd();
    send_frame(1'b1, 1'b1, 0, 0, 8);

    // reset held 3 cycles mid-frame
    fill_rnd();
    send_frame(1'b1, 1'b0, 0, 0, 5);
    rst = 1'b1;
    rst_cyc(8'd5, 1'b0);
    rst_cyc(8'd6, 1'b0);
    rst_cyc(8'd7, 1'b0);
    rst = 1'b0;
    fill_rnd();
    send_frame(1'b0, 1'b0, 99, 0, 8);
    fill_rnd();
    send_frame(1'b1, 1'b1, 4, 0, 8);
    fill_rnd();
    send_frame(1'b1, 1'b0, 0, 0, 8);

    // rst and sync_in together: no lock
    rst = 1'b1;
    rst_cyc(8'd0, 1'b1);
    rst = 1'b0;
    fill_rnd();
    send_frame(1'b0, 1'b0, 99, 1, 8);
    send_frame(1'b0, 1'b0, 99, 0, 8);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
